// File: rtl/home_auto_pkg.sv
// Shared types and constants for the keypad code entry path.
// Contents:
//   kp_state_t     entry FSM state (IDLE, COLLECT, SEND)
//   KEY_CLEAR      key code that abandons a partially entered code
//   KEY_DIGIT_MAX  highest key code that counts as a digit
package home_auto_pkg;

    typedef enum logic [1:0] {
        IDLE,
        COLLECT,
        SEND
    } kp_state_t;

    localparam logic [3:0] KEY_CLEAR     = 4'hC;
    localparam logic [3:0] KEY_DIGIT_MAX = 4'h9;

endpackage

// File: rtl/key_debouncer.sv
// Debounces the raw key-down level from the keypad scanner.
// Ports:
//   clk          in   system clock, rising edge
//   rst          in   asynchronous active-low reset
//   key_valid    in   raw key-down level
//   press_pulse  out  one-cycle pulse in the cycle a press is accepted
// A press is accepted in the cycle key_valid has been high for DEBOUNCE_CYC consecutive
// cycles. Another press is not accepted until key_valid has been low for DEBOUNCE_CYC
// consecutive cycles. Shorter highs or lows are ignored.
module key_debouncer #(
    parameter int unsigned DEBOUNCE_CYC = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic key_valid,
    output logic press_pulse
);

    localparam int unsigned CntW = $clog2(DEBOUNCE_CYC + 1);
    localparam logic [CntW-1:0] CntLast = CntW'(DEBOUNCE_CYC - 1);

    // armed_q=1: waiting for a stable high (press); armed_q=0: waiting for a stable low.
    // cnt_q counts earlier consecutive cycles at the level being waited for.
    logic            armed_q, armed_d;
    logic [CntW-1:0] cnt_q, cnt_d;

    always_comb begin
        armed_d     = armed_q;
        cnt_d       = cnt_q;
        press_pulse = 1'b0;
        if (key_valid == armed_q) begin
            if (cnt_q == CntLast) begin
                armed_d     = ~armed_q;
                cnt_d       = '0;
                press_pulse = armed_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end else begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            armed_q <= 1'b1;
            cnt_q   <= '0;
        end else begin
            armed_q <= armed_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: rtl/keypad_code_transmitter.sv
// Turns debounced keypad presses into a complete DIGITS-digit access code and hands it
// to the lock-decision logic with a valid/ready handshake.
// Ports:
//   clk          in   system clock, rising edge
//   rst          in   asynchronous active-low reset
//   key_valid    in   raw key-down level from the scanner
//   key_value    in   key code: 0x0-0x9 digit, 0xC clear, others ignored
//   code_data    out  assembled code, first digit in the most significant nibble
//   code_valid   out  code_data holds a complete code
//   code_ready   in   downstream accepts; transfer on code_valid && code_ready
//   entry_busy   out  high while collecting or sending
//   timeout_err  out  one-cycle pulse when an entry is abandoned for inactivity
module keypad_code_transmitter
    import home_auto_pkg::*;
#(
    parameter int unsigned DIGITS       = 4,
    parameter int unsigned DEBOUNCE_CYC = 4,
    parameter int unsigned TIMEOUT_CYC  = 1000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  key_valid,
    input  logic [3:0]            key_value,
    output logic [DIGITS*4-1:0]   code_data,
    output logic                  code_valid,
    input  logic                  code_ready,
    output logic                  entry_busy,
    output logic                  timeout_err
);

    localparam int unsigned W     = DIGITS * 4;
    localparam int unsigned CntW  = $clog2(DIGITS + 1);
    localparam int unsigned IdleW = $clog2(TIMEOUT_CYC + 1);

    localparam logic [CntW-1:0]  DigitsFull = CntW'(DIGITS);
    localparam logic [CntW-1:0]  FirstCnt   = CntW'(1);
    localparam logic [IdleW-1:0] IdleLast   = IdleW'(TIMEOUT_CYC - 1);
    localparam logic [IdleW-1:0] IdleMax    = IdleW'(TIMEOUT_CYC);

    kp_state_t        state_q, state_d;
    logic [W-1:0]     code_q, code_d;
    logic             valid_q, valid_d;
    logic             busy_q, busy_d;
    logic             timeout_q, timeout_d;
    logic [CntW-1:0]  digit_cnt_q, digit_cnt_d;
    logic [IdleW-1:0] idle_cnt_q, idle_cnt_d;

    logic             press_pulse;
    logic             is_digit;
    logic             is_clear;
    logic [W-1:0]     shifted;
    logic [CntW-1:0]  cnt_inc;

    key_debouncer #(
        .DEBOUNCE_CYC (DEBOUNCE_CYC)
    ) u_key_debouncer (
        .clk         (clk),
        .rst         (rst),
        .key_valid   (key_valid),
        .press_pulse (press_pulse)
    );

    // key_value is taken in the same cycle the debouncer accepts the press.
    assign is_digit = press_pulse && (key_value <= KEY_DIGIT_MAX);
    assign is_clear = press_pulse && (key_value == KEY_CLEAR);
    assign shifted  = (code_q << 4) | W'(key_value);
    assign cnt_inc  = digit_cnt_q + 1'b1;

    always_comb begin
        state_d     = state_q;
        code_d      = code_q;
        valid_d     = valid_q;
        digit_cnt_d = digit_cnt_q;
        idle_cnt_d  = idle_cnt_q;
        timeout_d   = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (is_digit) begin
                    code_d      = W'(key_value);
                    digit_cnt_d = FirstCnt;
                    idle_cnt_d  = '0;
                    if (FirstCnt == DigitsFull) begin
                        state_d = SEND;
                        valid_d = 1'b1;
                    end else begin
                        state_d = COLLECT;
                    end
                end
            end

            COLLECT: begin
                // Priority: digit, then clear, then timeout.
                if (is_digit) begin
                    code_d      = shifted;
                    digit_cnt_d = cnt_inc;
                    idle_cnt_d  = '0;
                    if (cnt_inc == DigitsFull) begin
                        state_d = SEND;
                        valid_d = 1'b1;
                    end
                end else if (is_clear) begin
                    code_d      = '0;
                    digit_cnt_d = '0;
                    idle_cnt_d  = '0;
                    state_d     = IDLE;
                end else if (idle_cnt_q == IdleLast) begin
                    code_d      = '0;
                    digit_cnt_d = '0;
                    idle_cnt_d  = '0;
                    timeout_d   = 1'b1;
                    state_d     = IDLE;
                end else if (idle_cnt_q != IdleMax) begin
                    idle_cnt_d = idle_cnt_q + 1'b1;
                end
            end

            SEND: begin
                // Keys are ignored and the code is held until the handshake completes.
                if (code_ready) begin
                    code_d      = '0;
                    valid_d     = 1'b0;
                    digit_cnt_d = '0;
                    idle_cnt_d  = '0;
                    state_d     = IDLE;
                end
            end

            default: begin
                code_d      = '0;
                valid_d     = 1'b0;
                digit_cnt_d = '0;
                idle_cnt_d  = '0;
                state_d     = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            code_q      <= '0;
            valid_q     <= 1'b0;
            busy_q      <= 1'b0;
            timeout_q   <= 1'b0;
            digit_cnt_q <= '0;
            idle_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            code_q      <= code_d;
            valid_q     <= valid_d;
            busy_q      <= busy_d;
            timeout_q   <= timeout_d;
            digit_cnt_q <= digit_cnt_d;
            idle_cnt_q  <= idle_cnt_d;
        end
    end

    assign code_data   = code_q;
    assign code_valid  = valid_q;
    assign entry_busy  = busy_q;
    assign timeout_err = timeout_q;

endmodule

// File: tb/tb_keypad_code_transmitter.sv
// Directed bench for keypad_code_transmitter with DIGITS=4, DEBOUNCE_CYC=4, TIMEOUT_CYC=50.
module tb_keypad_code_transmitter;

    logic        clk;
    logic        rst;
    logic        key_valid;
    logic [3:0]  key_value;
    logic [15:0] code_data;
    logic        code_valid;
    logic        code_ready;
    logic        entry_busy;
    logic        timeout_err;

    int n_checks = 0;
    int n_errors = 0;

    // Handshake monitor, sampled on the falling edge.
    int          xfer_cnt   = 0;
    logic [15:0] xfer_data  = '0;
    int          valid_cyc  = 0;
    int          to_cyc     = 0;

    keypad_code_transmitter #(
        .DIGITS       (4),
        .DEBOUNCE_CYC (4),
        .TIMEOUT_CYC  (50)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .key_valid   (key_valid),
        .key_value   (key_value),
        .code_data   (code_data),
        .code_valid  (code_valid),
        .code_ready  (code_ready),
        .entry_busy  (entry_busy),
        .timeout_err (timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rst) begin
            if (code_valid && code_ready) begin
                xfer_cnt  <= xfer_cnt + 1;
                xfer_data <= code_data;
            end
            if (code_valid) valid_cyc <= valid_cyc + 1;
            if (timeout_err) to_cyc <= to_cyc + 1;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic press(input logic [3:0] v);
        key_valid = 1'b1;
        key_value = v;
        cyc(6);
        key_valid = 1'b0;
        cyc(6);
    endtask

    task automatic enter4(input logic [15:0] c);
        logic [15:0] tmp;
        tmp = c;
        for (int i = 3; i >= 0; i--) press(tmp[i*4 +: 4]);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int  base;
        bit  seen;

        rst        = 1'b0;
        key_valid  = 1'b0;
        key_value  = 4'h0;
        code_ready = 1'b1;
        cyc(3);
        check_eq("rst_data", code_data, 16'h0);
        check_eq("rst_valid", code_valid, 1'b0);
        check_eq("rst_busy", entry_busy, 1'b0);
        check_eq("rst_timeout", timeout_err, 1'b0);
        rst = 1'b1;
        cyc(2);

        // Basic entry with ready held high.
        valid_cyc = 0;
        press(4'h1);
        check_eq("busy_after_first", entry_busy, 1'b1);
        press(4'h2);
        press(4'h3);
        press(4'h4);
        check_eq("t1_xfer_cnt", xfer_cnt, 1);
        check_eq("t1_xfer_data", xfer_data, 16'h1234);
        check_eq("t1_valid_cycles", valid_cyc, 1);
        check_eq("t1_busy_end", entry_busy, 1'b0);
        check_eq("t1_data_cleared", code_data, 16'h0);

        // Backpressure: code held while ready is low, extra key ignored.
        code_ready = 1'b0;
        base = xfer_cnt;
        enter4(16'h1234);
        check_eq("t2_valid_held", code_valid, 1'b1);
        check_eq("t2_data_held", code_data, 16'h1234);
        cyc(10);
        press(4'h7);
        check_eq("t2_valid_after7", code_valid, 1'b1);
        check_eq("t2_data_after7", code_data, 16'h1234);
        check_eq("t2_no_xfer", xfer_cnt, base);
        code_ready = 1'b1;
        cyc(2);
        check_eq("t2_xfer_cnt", xfer_cnt, base + 1);
        check_eq("t2_xfer_data", xfer_data, 16'h1234);
        check_eq("t2_valid_low", code_valid, 1'b0);
        check_eq("t2_busy_low", entry_busy, 1'b0);

        // Glitch shorter than the debounce window, and a non-digit key in IDLE.
        key_valid = 1'b1;
        key_value = 4'h5;
        cyc(3);
        key_valid = 1'b0;
        cyc(6);
        check_eq("t3_glitch_busy", entry_busy, 1'b0);
        check_eq("t3_glitch_data", code_data, 16'h0);
        press(4'hA);
        check_eq("t3_keyA_busy", entry_busy, 1'b0);
        press(4'hC);
        check_eq("t3_clear_idle_busy", entry_busy, 1'b0);

        // Timeout after two digits, then a fresh entry.
        to_cyc = 0;
        press(4'h1);
        press(4'h2);
        check_eq("t4_busy_pre_to", entry_busy, 1'b1);
        check_eq("t4_no_early_to", to_cyc, 0);
        seen = 1'b0;
        for (int i = 0; i < 60 && !seen; i++) begin
            cyc(1);
            if (timeout_err) seen = 1'b1;
        end
        check_eq("t4_timeout_seen", seen, 1'b1);
        cyc(1);
        check_eq("t4_timeout_pulse_low", timeout_err, 1'b0);
        check_eq("t4_timeout_width", to_cyc, 1);
        check_eq("t4_busy_after_to", entry_busy, 1'b0);
        check_eq("t4_data_after_to", code_data, 16'h0);
        base = xfer_cnt;
        enter4(16'h9876);
        check_eq("t4_xfer_cnt", xfer_cnt, base + 1);
        check_eq("t4_xfer_data", xfer_data, 16'h9876);

        // Clear mid-entry.
        base   = xfer_cnt;
        to_cyc = 0;
        press(4'h1);
        press(4'h2);
        press(4'hC);
        check_eq("t5_busy_after_clear", entry_busy, 1'b0);
        check_eq("t5_data_after_clear", code_data, 16'h0);
        enter4(16'h5678);
        check_eq("t5_xfer_cnt", xfer_cnt, base + 1);
        check_eq("t5_xfer_data", xfer_data, 16'h5678);
        check_eq("t5_no_timeout", to_cyc, 0);

        // Reset while sending.
        code_ready = 1'b0;
        base = xfer_cnt;
        enter4(16'h2468);
        check_eq("t6_valid_pre_rst", code_valid, 1'b1);
        rst = 1'b0;
        #1;
        check_eq("t6_valid_async", code_valid, 1'b0);
        check_eq("t6_data_async", code_data, 16'h0);
        check_eq("t6_busy_async", entry_busy, 1'b0);
        code_ready = 1'b1;
        cyc(2);
        rst = 1'b1;
        cyc(2);
        check_eq("t6_no_xfer", xfer_cnt, base);
        enter4(16'h4321);
        check_eq("t6_post_xfer_cnt", xfer_cnt, base + 1);
        check_eq("t6_post_xfer_data", xfer_data, 16'h4321);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
